// File: rtl/map_ss_seq_if.sv
// map_ss_seq_if
//   Groups the signals between the save-state sequencer and its surroundings.
//   Three groups share the bundle:
//   - Control: start, dir and abort in; busy, done and csum out.
//   - Mapper save-state port: ss_act, ss_we, ss_addr and ss_wdat out; ss_rdat in.
//   - Snapshot buffer port: buf_addr, buf_we and buf_wdat out; buf_rdat in.
//   Modports:
//   - master: the sequencer's view.
//   - slave:  the environment's view (controller, mapper and buffer).
interface map_ss_seq_if;
    logic       start;
    logic       dir;
    logic       abort;
    logic       busy;
    logic       done;
    logic [7:0] csum;
    logic       ss_act;
    logic       ss_we;
    logic [7:0] ss_addr;
    logic [7:0] ss_wdat;
    logic [7:0] ss_rdat;
    logic [4:0] buf_addr;
    logic       buf_we;
    logic [7:0] buf_wdat;
    logic [7:0] buf_rdat;

    modport master (
        input  start, dir, abort, ss_rdat, buf_rdat,
        output busy, done, csum, ss_act, ss_we, ss_addr, ss_wdat,
               buf_addr, buf_we, buf_wdat
    );

    modport slave (
        output start, dir, abort, ss_rdat, buf_rdat,
        input  busy, done, csum, ss_act, ss_we, ss_addr, ss_wdat,
               buf_addr, buf_we, buf_wdat
    );
endinterface

// File: rtl/map_ss_seq.sv
// map_ss_seq
//   Moves the mapper save-state between the mapper and a snapshot buffer.
//
//   Transfer directions:
//   - Save (dir=0) reads N_REG contiguous registers plus the mapper-index
//     register and writes them to the buffer, one entry per cycle.
//   - Restore (dir=1) reads the buffer and writes it back into the mapper.
//     Each entry takes two cycles because the buffer read is registered.
//
//   csum reports the XOR of every byte moved by the last completed transfer.
//
//   Ports:
//   - clk, map_rst: clock and synchronous active-high reset.
//   - bus (master): the control, mapper and buffer signals; see map_ss_seq_if.
module map_ss_seq #(
    parameter int N_REG    = 16,
    parameter int IDX_ADDR = 127
) (
    input  logic         clk,
    input  logic         map_rst,
    map_ss_seq_if.master bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARM   = 3'd1;
    localparam logic [2:0] S_SAVE  = 3'd2;
    localparam logic [2:0] S_FETCH = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [4:0] LAST_K = 5'(N_REG);
    localparam logic [7:0] IDX_A  = 8'(IDX_ADDR);

    logic [2:0] state;
    logic [4:0] k;
    logic       dir_q;
    logic [7:0] run_xor;
    logic [7:0] csum_q;
    logic       last_entry;
    logic [7:0] map_addr;

    // The final entry is the mapper-index register, which lives away from
    // the contiguous block; every other entry maps straight through.
    assign last_entry = (k == LAST_K);
    assign map_addr   = last_entry ? IDX_A : {3'b000, k};

    // Abort has priority over normal sequencing in every busy state. A start
    // pulse is only examined in IDLE, so a start while busy has no effect.
    always_ff @(posedge clk) begin
        if (map_rst) begin
            state   <= S_IDLE;
            k       <= 5'd0;
            dir_q   <= 1'b0;
            run_xor <= 8'h00;
            csum_q  <= 8'h00;
        end else if ((state != S_IDLE) && bus.abort) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        dir_q   <= bus.dir;
                        k       <= 5'd0;
                        run_xor <= 8'h00;
                        state   <= S_ARM;
                    end
                end
                S_ARM: begin
                    state <= dir_q ? S_FETCH : S_SAVE;
                end
                S_SAVE: begin
                    run_xor <= run_xor ^ bus.ss_rdat;
                    if (last_entry) begin
                        state <= S_DONE;
                    end else begin
                        k <= k + 5'd1;
                    end
                end
                S_FETCH: begin
                    state <= S_WRITE;
                end
                S_WRITE: begin
                    run_xor <= run_xor ^ bus.buf_rdat;
                    if (last_entry) begin
                        state <= S_DONE;
                    end else begin
                        k     <= k + 5'd1;
                        state <= S_FETCH;
                    end
                end
                S_DONE: begin
                    csum_q <= run_xor;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // The buffer address is held through WRITE, so that buf_rdat returned
    // in WRITE belongs to the entry that was presented in FETCH.
    always_comb begin
        bus.busy     = (state != S_IDLE);
        bus.done     = (state == S_DONE);
        bus.ss_act   = 1'b0;
        bus.ss_we    = 1'b0;
        bus.ss_addr  = 8'h00;
        bus.ss_wdat  = 8'h00;
        bus.buf_addr = 5'd0;
        bus.buf_we   = 1'b0;
        bus.buf_wdat = 8'h00;
        case (state)
            S_ARM: begin
                bus.ss_act = 1'b1;
            end
            S_SAVE: begin
                bus.ss_act   = 1'b1;
                bus.ss_addr  = map_addr;
                bus.buf_addr = k;
                bus.buf_we   = 1'b1;
                bus.buf_wdat = bus.ss_rdat;
            end
            S_FETCH: begin
                bus.ss_act   = 1'b1;
                bus.buf_addr = k;
            end
            S_WRITE: begin
                bus.ss_act   = 1'b1;
                bus.ss_we    = 1'b1;
                bus.ss_addr  = map_addr;
                bus.ss_wdat  = bus.buf_rdat;
                bus.buf_addr = k;
            end
            default: begin
            end
        endcase
    end

    assign bus.csum = csum_q;

endmodule

// File: tb/tb_map_ss_seq.sv
// tb_map_ss_seq
//   Scoreboard bench for map_ss_seq.
//
//   The bench models the environment around the sequencer:
//   - a 256-entry mapper register file with combinational reads;
//   - a 32-entry snapshot buffer with registered reads.
//
//   A behavioural model owns its own copies of both memories. For each
//   transfer, the model queues the expected strobes (cycle, address, data)
//   and the expected done pulse with its checksum. A monitor on the falling
//   edge pops those queues whenever the DUT strobes.
module tb_map_ss_seq;

    localparam int N_REG    = 16;
    localparam int IDX_ADDR = 127;

    typedef struct {
        int         cyc;
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        int         cyc;
        logic [7:0] csum;
    } done_t;

    logic clk = 1'b0;
    logic map_rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    map_ss_seq_if bus ();

    map_ss_seq #(.N_REG(N_REG), .IDX_ADDR(IDX_ADDR)) dut (
        .clk     (clk),
        .map_rst (map_rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Environment memories. The bench preloads them through the ld_* port.
    logic [7:0] map_mem [256];
    logic [7:0] buf_mem [32];
    logic       ld_map_we = 1'b0;
    logic       ld_buf_we = 1'b0;
    logic [7:0] ld_addr   = 8'h00;
    logic [7:0] ld_dat    = 8'h00;

    assign bus.ss_rdat = map_mem[bus.ss_addr];

    always @(posedge clk) begin
        if (bus.ss_we) map_mem[bus.ss_addr] <= bus.ss_wdat;
        else if (ld_map_we) map_mem[ld_addr] <= ld_dat;
        bus.buf_rdat <= buf_mem[bus.buf_addr];
        if (bus.buf_we) buf_mem[bus.buf_addr] <= bus.buf_wdat;
        else if (ld_buf_we) buf_mem[ld_addr[4:0]] <= ld_dat;
    end

    // Reference model state and scoreboard queues.
    logic [7:0] m_map [256];
    logic [7:0] m_buf [32];
    logic [7:0] m_csum = 8'h00;
    wr_t   exp_ss  [$];
    wr_t   exp_buf [$];
    done_t exp_done[$];

    function automatic int entry_addr(input int e);
        return (e < N_REG) ? e : IDX_ADDR;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe and done pulse must match the head of its queue.
    logic       csum_pend = 1'b0;
    logic [7:0] csum_exp  = 8'h00;
    always @(negedge clk) begin
        wr_t   w;
        done_t d;
        if (map_rst !== 1'b1) begin
            check_output("ss_act_window", 32'(bus.ss_act), 32'(bus.busy & ~bus.done));
        end
        if (csum_pend) begin
            check_output("csum", 32'(bus.csum), 32'(csum_exp));
            csum_pend = 1'b0;
        end
        if (bus.ss_we === 1'b1) begin
            if (exp_ss.size() == 0) begin
                check_output("ss_we_expected", 32'd1, 32'd0);
            end else begin
                w = exp_ss.pop_front();
                check_output("ss_we_cycle", 32'(cyc), 32'(w.cyc));
                check_output("ss_addr", 32'(bus.ss_addr), 32'(w.addr));
                check_output("ss_wdat", 32'(bus.ss_wdat), 32'(w.data));
            end
        end
        if (bus.buf_we === 1'b1) begin
            if (exp_buf.size() == 0) begin
                check_output("buf_we_expected", 32'd1, 32'd0);
            end else begin
                w = exp_buf.pop_front();
                check_output("buf_we_cycle", 32'(cyc), 32'(w.cyc));
                check_output("buf_addr", 32'(bus.buf_addr), 32'(w.addr));
                check_output("buf_wdat", 32'(bus.buf_wdat), 32'(w.data));
            end
        end
        if (bus.done === 1'b1) begin
            if (exp_done.size() == 0) begin
                check_output("done_expected", 32'd1, 32'd0);
            end else begin
                d = exp_done.pop_front();
                check_output("done_cycle", 32'(cyc), 32'(d.cyc));
                csum_pend = 1'b1;
                csum_exp  = d.csum;
            end
        end
    end

    task automatic load_entry(input bit to_buf, input int a, input logic [7:0] v);
        @(negedge clk);
        ld_map_we = !to_buf;
        ld_buf_we = to_buf;
        ld_addr   = 8'(a);
        ld_dat    = v;
        if (to_buf) m_buf[a] = v;
        else        m_map[a] = v;
    endtask

    task automatic load_done();
        @(negedge clk);
        ld_map_we = 1'b0;
        ld_buf_we = 1'b0;
    endtask

    // Runs one transfer and feeds the model.
    //   cut_n:   cycle of an abort or reset, or -1 for none.
    //   extra_n: cycle of a stray start pulse, or -1 for none.
    // Expected timing: ARM is cycle 1. A save moves entry e in cycle 2+e.
    // A restore writes entry e in cycle 3+2e.
    task automatic apply_stimulus(input logic d, input int cut_n, input bit cut_rst, input int extra_n);
        int         c0, lat, wc, a, last_n;
        logic [7:0] v, x;
        @(negedge clk);
        c0  = cyc;
        lat = d ? 2 * N_REG + 4 : N_REG + 3;
        x   = 8'h00;
        for (int e = 0; e <= N_REG; e++) begin
            wc = d ? 3 + 2 * e : 2 + e;
            if (cut_n >= 0 && wc > cut_n) break;
            a = entry_addr(e);
            if (!d) begin
                v = m_map[a];
                m_buf[e] = v;
                exp_buf.push_back('{c0 + wc, 8'(e), v});
            end else begin
                v = m_buf[e];
                m_map[a] = v;
                exp_ss.push_back('{c0 + wc, 8'(a), v});
            end
            x = x ^ v;
        end
        if (cut_n < 0) begin
            exp_done.push_back('{c0 + lat, x});
            m_csum = x;
        end else if (cut_rst) begin
            m_csum = 8'h00;
        end
        last_n = (cut_n >= 0) ? cut_n : lat;
        bus.start = 1'b1;
        bus.dir   = d;
        for (int n = 1; n <= lat + 3; n++) begin
            @(negedge clk);
            bus.start = (n == extra_n);
            bus.dir   = 1'($urandom_range(0, 1));
            bus.abort = 1'b0;
            map_rst   = 1'b0;
            check_output("busy", 32'(bus.busy), 32'(n <= last_n));
            if (cut_n >= 0 && n == cut_n + 1) begin
                check_output("cut_ss_we", 32'(bus.ss_we), 32'd0);
                check_output("cut_buf_we", 32'(bus.buf_we), 32'd0);
                check_output("cut_ss_act", 32'(bus.ss_act), 32'd0);
                check_output("cut_done", 32'(bus.done), 32'd0);
                check_output("cut_csum", 32'(bus.csum), 32'(m_csum));
            end
            if (n == cut_n) begin
                if (cut_rst) map_rst = 1'b1;
                else         bus.abort = 1'b1;
            end
        end
        check_output("exp_ss_drained", 32'(exp_ss.size()), 32'd0);
        check_output("exp_buf_drained", 32'(exp_buf.size()), 32'd0);
        check_output("exp_done_drained", 32'(exp_done.size()), 32'd0);
        exp_ss.delete();
        exp_buf.delete();
        exp_done.delete();
    endtask

    task automatic compare_memories(input string tag);
        for (int e = 0; e <= N_REG; e++) begin
            check_output({tag, "_map"}, 32'(map_mem[entry_addr(e)]), 32'(m_map[entry_addr(e)]));
            check_output({tag, "_buf"}, 32'(buf_mem[e]), 32'(m_buf[e]));
        end
    endtask

    initial begin
        logic d;
        int   lat, cut, ex;
        bit   cr;

        bus.start = 1'b0;
        bus.dir   = 1'b0;
        bus.abort = 1'b0;
        map_rst   = 1'b1;
        repeat (3) @(negedge clk);
        check_output("rst_busy", 32'(bus.busy), 32'd0);
        check_output("rst_done", 32'(bus.done), 32'd0);
        check_output("rst_ss_act", 32'(bus.ss_act), 32'd0);
        check_output("rst_ss_we", 32'(bus.ss_we), 32'd0);
        check_output("rst_buf_we", 32'(bus.buf_we), 32'd0);
        check_output("rst_csum", 32'(bus.csum), 32'd0);
        map_rst = 1'b0;

        // Save of a known pattern: 0x10+k and index 0x41, checksum 0x41.
        for (int e = 0; e <= N_REG; e++) begin
            load_entry(1'b0, entry_addr(e), (e < N_REG) ? 8'(8'h10 + e) : 8'h41);
        end
        load_done();
        apply_stimulus(1'b0, -1, 1'b0, -1);
        check_output("save_csum_const", 32'(bus.csum), 32'h41);

        // Restore of 0xA0+k and 0x41, first clean, then with a stray start.
        for (int e = 0; e <= N_REG; e++) begin
            load_entry(1'b1, e, (e < N_REG) ? 8'(8'hA0 + e) : 8'h41);
        end
        load_done();
        apply_stimulus(1'b1, -1, 1'b0, -1);
        check_output("restore_csum_const", 32'(bus.csum), 32'h41);
        apply_stimulus(1'b1, -1, 1'b0, 10);

        // Abort in the WRITE of entry 5, then a reset in the save of entry 3.
        apply_stimulus(1'b1, 3 + 2 * 5, 1'b0, -1);
        apply_stimulus(1'b0, 2 + 3, 1'b1, -1);

        // Save then restore of random contents leaves the mapper unchanged.
        for (int e = 0; e <= N_REG; e++) begin
            load_entry(1'b0, entry_addr(e), 8'($urandom_range(0, 255)));
        end
        load_done();
        apply_stimulus(1'b0, -1, 1'b0, -1);
        apply_stimulus(1'b1, -1, 1'b0, -1);
        compare_memories("roundtrip");

        // Random mix of directions, data, aborts, resets and stray starts.
        for (int t = 0; t < 12; t++) begin
            d   = 1'($urandom_range(0, 1));
            lat = d ? 2 * N_REG + 4 : N_REG + 3;
            cut = -1;
            ex  = -1;
            cr  = 1'b0;
            if ($urandom_range(0, 2) == 0) begin
                for (int e = 0; e <= N_REG; e++) begin
                    if (d) load_entry(1'b1, e, 8'($urandom_range(0, 255)));
                    else   load_entry(1'b0, entry_addr(e), 8'($urandom_range(0, 255)));
                end
                load_done();
            end
            case ($urandom_range(0, 3))
                0: begin
                    cut = int'($urandom_range(1, lat - 1));
                    cr  = 1'($urandom_range(0, 1));
                end
                1: ex = int'($urandom_range(1, lat));
                default: begin
                end
            endcase
            apply_stimulus(d, cut, cr, ex);
        end
        compare_memories("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
